aux_uart_tx: RTL

AUX_UART_TX -- requirements
Module: aux_uart_tx

---
 rtl/aux_uart_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aux_uart_tx.sv
// Aux-bus UART transmitter: 4-deep byte FIFO feeding an 8N1 serializer whose
// bit period is BAUDDIV+1 enabled clocks.
module aux_uart_tx #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter logic [7:0]  DIV_RESET = 8'd9
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    input  logic [15:0] aux_adr_i,
    input  logic [7:0]  aux_dat_i,
    output logic [7:0]  aux_dat_o,
    output logic        aux_oe_o,
    input  logic        aux_we_i,
    input  logic        aux_re_i,
    output logic        txd_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [15:0] ADR_TXDATA = BASE_ADDR;
    localparam logic [15:0] ADR_STATUS = BASE_ADDR + 16'd1;
    localparam logic [15:0] ADR_DIV    = BASE_ADDR + 16'd2;

    state_t      state_q, state_d;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  baud_q, baud_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  div_q, div_d;
    logic        txd_q, txd_d;
    logic        irq_q, irq_d;
    logic        ovf_q, ovf_d;

    logic        sel_tx, sel_st, sel_div;
    logic        wr_tx, wr_st, wr_div;
    logic        full, empty, boundary, push, pop;
    logic [7:0]  status;

    assign sel_tx  = (aux_adr_i == ADR_TXDATA);
    assign sel_st  = (aux_adr_i == ADR_STATUS);
    assign sel_div = (aux_adr_i == ADR_DIV);
    assign wr_tx   = aux_we_i & clk_en_i & sel_tx;
    assign wr_st   = aux_we_i & clk_en_i & sel_st;
    assign wr_div  = aux_we_i & clk_en_i & sel_div;

    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0);
    assign boundary = (baud_q == 8'd0);

    assign status    = {4'b0000, ovf_q, (state_q != S_IDLE), empty, full};
    assign aux_oe_o  = aux_re_i & (sel_st | sel_div);
    assign aux_dat_o = !aux_oe_o ? 8'h00 : (sel_st ? status : div_q);

    assign txd_o = txd_q;
    assign irq_o = irq_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_q[rd_ptr_q];
                    baud_d   = div_q;
                    bitcnt_d = 3'd0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (!boundary) begin
                    baud_d = baud_q - 8'd1;
                end else begin
                    baud_d  = div_q;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!boundary) begin
                    baud_d = baud_q - 8'd1;
                end else begin
                    baud_d  = div_q;
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == 3'd7) state_d = S_STOP;
                    else                  bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            S_STOP: begin
                if (!boundary) begin
                    baud_d = baud_q - 8'd1;
                end else if (!empty) begin
                    // back-to-back frame: next start bit follows the stop bit directly
                    pop      = 1'b1;
                    shift_d  = fifo_q[rd_ptr_q];
                    baud_d   = div_q;
                    bitcnt_d = 3'd0;
                    state_d  = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        // a pop in the same cycle frees a slot, so a write to a full FIFO still lands
        push     = wr_tx & (!full | pop);
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, push} - {2'b00, pop};

        ovf_d = ovf_q;
        if (wr_st)                     ovf_d = 1'b0;
        else if (wr_tx & full & !pop)  ovf_d = 1'b1;

        div_d = wr_div ? aux_dat_i : div_q;
        irq_d = (state_d == S_IDLE) && (count_d == 3'd0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            shift_q  <= 8'd0;
            baud_q   <= 8'd0;
            bitcnt_q <= 3'd0;
            div_q    <= DIV_RESET;
            txd_q    <= 1'b1;
            irq_q    <= 1'b1;
            ovf_q    <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && push) fifo_q[wr_ptr_q] <= aux_dat_i;
    end

endmodule
